hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
Pipeline hazard controller for the 5-stage ARM-style processor. It drives the fetch/decode control inputs of the datapath: StallF, StallD, FlushD and PCSrcW. It also drives the execute-stage control FlushE and the ALU operand forwarding selects.
- Keeps its own shadow of destination-register and control bits for the E, M and W stages, taken from decode-stage fields.
- Detects load-use, RAW forwarding, PC-write (R15) and taken-branch hazards.
- Counts stall and flush events for performance debug.

Parameters:
- CNT_W, 16, width of the saturating stall/flush event counters.
- REG_AW, 4, register address width (R0..R15).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- RA1D  in  REG_AW  decode source register 1 (after RegSrc muxing).
- RA2D  in  REG_AW  decode source register 2 (after RegSrc muxing).
- WA3D  in  REG_AW  decode destination register.
- RegWriteD  in  1  decode instruction writes the register file.
- MemtoRegD  in  1  decode instruction is a load.
- PCSrcD  in  1  decode instruction writes R15.
- BranchTakenE  in  1  execute-stage branch resolved taken.
- StallF  out  1  1 = hold PC register.
- StallD  out  1  1 = hold fetch/decode register.
- FlushD  out  1  1 = clear fetch/decode register to 0.
- FlushE  out  1  1 = clear decode/execute register (bubble).
- ForwardAE  out  2  SrcA select: 00 register file, 01 ResultW, 10 ALUResultM.
- ForwardBE  out  2  SrcB select, same encoding.
- PCSrcW  out  1  writeback-stage R15 write (selects ResultW into PC mux).
- stall_cnt  out  CNT_W  cycles with StallD=1, saturating.
- flush_cnt  out  CNT_W  cycles with FlushD=1, saturating.

Behaviour:
- Shadow pipeline, D->E register, captured every posedge unless rst:
  - Captures RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD into the *E versions.
  - If FlushE=1 at that edge: the E register loads zeros (bubble); addresses go to 0 and all control bits go to 0.
- E->M and M->W shadow registers capture unconditionally each cycle (no stall beyond decode).
- Reset: all shadow registers and both counters go to 0 on the clock edge where rst=1. While rst=1 the outputs are:
  - StallF = StallD = 0, FlushD = FlushE = 1.
  - ForwardAE = ForwardBE = 00, PCSrcW = 0.
  - Reset mid-stall clears the pending load-use; the first cycle after reset has no stall.
- Combinational outputs, same-cycle from the current state and inputs:
  - Forwarding for ForwardAE (ForwardBE identical using RA2E):
    - 10 if RegWriteM and WA3M==RA1E and RA1E!=4'hF.
    - else 01 if RegWriteW and WA3W==RA1E and RA1E!=4'hF.
    - else 00.
    - M has priority over W when both match.
  - Load-use: LDRstall = MemtoRegE & RegWriteE & (RA1D==WA3E | RA2D==WA3E).
  - PC write pending: PCWrPend = PCSrcD | PCSrcE | PCSrcM.
  - StallF = LDRstall | PCWrPend.
  - StallD = LDRstall.
  - FlushD = PCWrPend | PCSrcW | BranchTakenE.
  - FlushE = LDRstall | BranchTakenE.
  - PCSrcW = shadow PCSrcW.
- Simultaneous events:
  - LDRstall and BranchTakenE together: FlushE=1, FlushD=1, StallD=1. The datapath gives flush priority over stall on the D register.
  - PCWrPend together with LDRstall: StallF=1, StallD=1, FlushD=1.
- Counters:
  - stall_cnt increments on each posedge where StallD=1 and rst=0.
  - flush_cnt increments on each posedge where FlushD=1 and rst=0.
  - Both hold at 2^CNT_W-1 (no wrap).
- Latency:
  - Forward/stall/flush outputs have zero-cycle latency relative to the inputs.
  - A load in D raises LDRstall exactly one cycle later, when the load sits in E, for a dependent instruction in D.

Decomposition:
- Package hazard_pkg:
  - enum fwd_sel_t: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - constant REG_PC=4'hF.
  - struct stage_ctl_t {wa3, reg_write, mem_to_reg, pc_src}.
- Sub-module hazard_stage_reg: stage_ctl_t register with sync rst and sync clear. Instantiated for E (clear=FlushE), M and W (clear tied 0).

Test Plan:
1. Load-use: LDR R2 in D (RegWriteD=1, MemtoRegD=1, WA3D=2); next cycle ADD with RA1D=2 -> that cycle StallF=StallD=FlushE=1. Following cycle all 0, stall_cnt=1.
2. Forward priority: WA3M=3/RegWriteM=1 and WA3W=3/RegWriteW=1 with RA1E=3 -> ForwardAE=10. With RegWriteM=0 -> ForwardAE=01. With RA2E=5 unmatched -> ForwardBE=00.
3. R15 exclusion: RegWriteM=1, WA3M=15, RA1E=15 -> ForwardAE=00.
4. PC write: PCSrcD=1 for one cycle -> StallF=1 and FlushD=1 for 3 consecutive cycles (D, E, M). Then PCSrcW=1 with FlushD=1 and StallF=0 for 1 cycle; flush_cnt=4.
5. Branch: BranchTakenE=1 with no other hazard -> FlushD=FlushE=1, StallF=0. Next cycle E shadow is zeros (RegWriteE=0).
6. Reset mid-stall: assert rst during a load-use stall -> during rst FlushD=FlushE=1, StallD=0. After release all outputs 0, stall_cnt=0. Also force 65535 stall cycles -> stall_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding select encoding,
// the per-stage control shadow record and the forwarding priority helper.
package hazard_pkg;

  localparam logic [3:0] REG_PC = 4'hF;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic [3:0] wa3;
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_src;
  } stage_ctl_t;

  // The PC is never forwarded because its value is supplied by the datapath, not by writeback.
  function automatic fwd_sel_t fwdSelect(input logic [3:0] ra, input stage_ctl_t ctlM,
                                         input stage_ctl_t ctlW);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (ra != REG_PC) begin
      if (ctlM.reg_write && (ctlM.wa3 == ra)) begin
        sel = FWD_MEM;
      end else if (ctlW.reg_write && (ctlW.wa3 == ra)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline-stage shadow of destination register and control bits.
// A clear loads an all-zero record, which is the bubble encoding.
module hazard_stage_reg
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  stage_ctl_t d,
  output stage_ctl_t q
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage pipeline: forwarding selects, load-use stall,
// PC-write and branch flushes, plus saturating stall/flush event counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int REG_AW = 4
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] RA1D,
  input  logic [REG_AW-1:0] RA2D,
  input  logic [REG_AW-1:0] WA3D,
  input  logic              RegWriteD,
  input  logic              MemtoRegD,
  input  logic              PCSrcD,
  input  logic              BranchTakenE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              PCSrcW,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  stage_ctl_t        ctlD, ctlE, ctlM, ctlW;
  logic [REG_AW-1:0] RA1E, RA2E;
  logic              ldrStall;
  logic              pcWrPend;
  fwd_sel_t          fwdA, fwdB;

  assign ctlD = '{wa3: WA3D, reg_write: RegWriteD, mem_to_reg: MemtoRegD, pc_src: PCSrcD};

  hazard_stage_reg stageE (
    .clk   (clk),
    .rst   (rst),
    .clear (FlushE),
    .d     (ctlD),
    .q     (ctlE)
  );

  hazard_stage_reg stageM (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .d     (ctlE),
    .q     (ctlM)
  );

  hazard_stage_reg stageW (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .d     (ctlM),
    .q     (ctlW)
  );

  // Source addresses travel with the E record so a bubble cannot match anything stale.
  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      RA1E <= '0;
      RA2E <= '0;
    end else begin
      RA1E <= RA1D;
      RA2E <= RA2D;
    end
  end

  always_comb begin
    ldrStall = ctlE.mem_to_reg & ctlE.reg_write &
               ((RA1D == ctlE.wa3) | (RA2D == ctlE.wa3));
    pcWrPend = ctlD.pc_src | ctlE.pc_src | ctlM.pc_src;
    fwdA     = fwdSelect(RA1E, ctlM, ctlW);
    fwdB     = fwdSelect(RA2E, ctlM, ctlW);

    if (rst) begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      PCSrcW    = 1'b0;
    end else begin
      StallF    = ldrStall | pcWrPend;
      StallD    = ldrStall;
      FlushD    = pcWrPend | ctlW.pc_src | BranchTakenE;
      FlushE    = ldrStall | BranchTakenE;
      ForwardAE = fwdA;
      ForwardBE = fwdB;
      PCSrcW    = ctlW.pc_src;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallD && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (FlushD && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: a cycle-by-cycle vector table run through
// an expected-value queue, then counter saturation sequences.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  RA1D, RA2D, WA3D;
  logic        RegWriteD, MemtoRegD, PCSrcD, BranchTakenE;
  logic        StallF, StallD, FlushD, FlushE, PCSrcW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] stall_cnt, flush_cnt;

  logic        sStallF, sStallD, sFlushD, sFlushE, sPCSrcW;
  logic [1:0]  sForwardAE, sForwardBE;
  logic [2:0]  sStallCnt, sFlushCnt;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk(clk), .rst(rst), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD),
    .BranchTakenE(BranchTakenE), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .PCSrcW(PCSrcW), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  // Narrow-counter copy so stall saturation is reachable in a short run.
  hazard_unit #(.CNT_W(3)) dutS (
    .clk(clk), .rst(rst), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD),
    .BranchTakenE(BranchTakenE), .StallF(sStallF), .StallD(sStallD),
    .FlushD(sFlushD), .FlushE(sFlushE), .ForwardAE(sForwardAE),
    .ForwardBE(sForwardBE), .PCSrcW(sPCSrcW), .stall_cnt(sStallCnt),
    .flush_cnt(sFlushCnt)
  );

  typedef struct packed {
    logic        rst;
    logic [3:0]  ra1, ra2, wa3;
    logic        rw, mtr, pcs, bt;
  } in_t;

  typedef struct packed {
    logic        sf, sd, fd, fe;
    logic [1:0]  fa, fb;
    logic        pw;
    logic [15:0] sc, fc;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  vec_t        vecs[$];
  exp_t        sbq[$];
  logic [15:0] cntq[$];
  int          checks = 0;
  int          errors = 0;

  function automatic in_t mkI(logic r, logic [3:0] a1, logic [3:0] a2, logic [3:0] w,
                              logic rw, logic mtr, logic pcs, logic bt);
    in_t v;
    v = '{rst: r, ra1: a1, ra2: a2, wa3: w, rw: rw, mtr: mtr, pcs: pcs, bt: bt};
    return v;
  endfunction

  function automatic exp_t mkE(logic sf, logic sd, logic fd, logic fe, logic [1:0] fa,
                               logic [1:0] fb, logic pw, int sc, int fc);
    exp_t v;
    v = '{sf: sf, sd: sd, fd: fd, fe: fe, fa: fa, fb: fb, pw: pw, sc: sc[15:0], fc: fc[15:0]};
    return v;
  endfunction

  task automatic drive(input in_t i);
    rst          = i.rst;
    RA1D         = i.ra1;
    RA2D         = i.ra2;
    WA3D         = i.wa3;
    RegWriteD    = i.rw;
    MemtoRegD    = i.mtr;
    PCSrcD       = i.pcs;
    BranchTakenE = i.bt;
  endtask

  task automatic step(input in_t i);
    @(posedge clk);
    #1;
    drive(i);
  endtask

  task automatic compareOut(input string nm);
    exp_t x, a;
    x = sbq.pop_front();
    a = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, PCSrcW, stall_cnt, flush_cnt};
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got SF/SD/FD/FE/FA/FB/PW=%b stall=%0d flush=%0d, expected %b stall=%0d flush=%0d",
               nm, a[40:32], a.sc, a.fc, x[40:32], x.sc, x.fc);
    end
  endtask

  task automatic checkCnt(input string nm, input logic [15:0] act);
    logic [15:0] x;
    x = cntq.pop_front();
    checks++;
    if (act !== x) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, x);
    end
  endtask

  in_t nop, ldr2, dep2;

  initial begin
    nop  = mkI(0, 0, 0, 0, 0, 0, 0, 0);
    ldr2 = mkI(0, 0, 0, 2, 1, 1, 0, 0);
    dep2 = mkI(0, 2, 0, 4, 1, 0, 0, 0);

    //                 rst ra1 ra2 wa3 rw mtr pcs bt      sf sd fd fe fa fb pw sc fc
    vecs.push_back('{mkI(1, 0, 0, 0, 0, 0, 0, 0), mkE(0, 0, 1, 1, 0, 0, 0, 0, 0)});
    vecs.push_back('{mkI(0, 1, 0, 2, 1, 1, 0, 0), mkE(0, 0, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{mkI(0, 2, 3, 4, 1, 0, 0, 0), mkE(1, 1, 0, 1, 0, 0, 0, 0, 0)});
    vecs.push_back('{mkI(0, 2, 3, 4, 1, 0, 0, 0), mkE(0, 0, 0, 0, 0, 0, 0, 1, 0)});
    vecs.push_back('{mkI(0, 6, 7, 5, 1, 0, 0, 0), mkE(0, 0, 0, 0, 1, 0, 0, 1, 0)});
    vecs.push_back('{mkI(0, 0, 0, 3, 1, 0, 0, 0), mkE(0, 0, 0, 0, 0, 0, 0, 1, 0)});
    vecs.push_back('{mkI(0, 0, 0, 3, 1, 0, 0, 0), mkE(0, 0, 0, 0, 0, 0, 0, 1, 0)});
    vecs.push_back('{mkI(0, 3, 5, 9, 1, 0, 0, 0), mkE(0, 0, 0, 0, 0, 0, 0, 1, 0)});
    vecs.push_back('{nop,                         mkE(0, 0, 0, 0, 2, 0, 0, 1, 0)});
    vecs.push_back('{mkI(0, 0, 0, 3, 1, 0, 0, 0), mkE(0, 0, 0, 0, 0, 0, 0, 1, 0)});
    vecs.push_back('{mkI(0, 0, 0, 3, 0, 0, 0, 0), mkE(0, 0, 0, 0, 0, 0, 0, 1, 0)});
    vecs.push_back('{mkI(0, 3, 3, 0, 0, 0, 0, 0), mkE(0, 0, 0, 0, 0, 0, 0, 1, 0)});
    vecs.push_back('{nop,                         mkE(0, 0, 0, 0, 1, 1, 0, 1, 0)});
    vecs.push_back('{mkI(0, 0, 0, 15, 1, 0, 0, 0), mkE(0, 0, 0, 0, 0, 0, 0, 1, 0)});
    vecs.push_back('{mkI(0, 15, 15, 1, 1, 0, 0, 0), mkE(0, 0, 0, 0, 0, 0, 0, 1, 0)});
    vecs.push_back('{nop,                         mkE(0, 0, 0, 0, 0, 0, 0, 1, 0)});
    vecs.push_back('{nop,                         mkE(0, 0, 0, 0, 0, 0, 0, 1, 0)});
    vecs.push_back('{mkI(0, 0, 0, 15, 1, 0, 1, 0), mkE(1, 0, 1, 0, 0, 0, 0, 1, 0)});
    vecs.push_back('{nop,                         mkE(1, 0, 1, 0, 0, 0, 0, 1, 1)});
    vecs.push_back('{nop,                         mkE(1, 0, 1, 0, 0, 0, 0, 1, 2)});
    vecs.push_back('{nop,                         mkE(0, 0, 1, 0, 0, 0, 1, 1, 3)});
    vecs.push_back('{nop,                         mkE(0, 0, 0, 0, 0, 0, 0, 1, 4)});
    vecs.push_back('{mkI(0, 1, 2, 6, 1, 1, 0, 1), mkE(0, 0, 1, 1, 0, 0, 0, 1, 4)});
    vecs.push_back('{mkI(0, 6, 0, 0, 0, 0, 0, 0), mkE(0, 0, 0, 0, 0, 0, 0, 1, 5)});
    vecs.push_back('{nop,                         mkE(0, 0, 0, 0, 0, 0, 0, 1, 5)});
    vecs.push_back('{ldr2,                        mkE(0, 0, 0, 0, 0, 0, 0, 1, 5)});
    vecs.push_back('{mkI(0, 2, 0, 4, 1, 0, 0, 1), mkE(1, 1, 1, 1, 0, 0, 0, 1, 5)});
    vecs.push_back('{nop,                         mkE(0, 0, 0, 0, 0, 0, 0, 2, 6)});
    vecs.push_back('{ldr2,                        mkE(0, 0, 0, 0, 0, 0, 0, 2, 6)});
    vecs.push_back('{mkI(0, 2, 0, 15, 1, 0, 1, 0), mkE(1, 1, 1, 1, 0, 0, 0, 2, 6)});
    vecs.push_back('{mkI(0, 2, 0, 15, 1, 0, 1, 0), mkE(1, 0, 1, 0, 0, 0, 0, 3, 7)});
    vecs.push_back('{nop,                         mkE(1, 0, 1, 0, 1, 0, 0, 3, 8)});
    vecs.push_back('{nop,                         mkE(1, 0, 1, 0, 0, 0, 0, 3, 9)});
    vecs.push_back('{nop,                         mkE(0, 0, 1, 0, 0, 0, 1, 3, 10)});
    vecs.push_back('{nop,                         mkE(0, 0, 0, 0, 0, 0, 0, 3, 11)});
    vecs.push_back('{ldr2,                        mkE(0, 0, 0, 0, 0, 0, 0, 3, 11)});
    vecs.push_back('{mkI(1, 2, 0, 4, 1, 0, 0, 0), mkE(0, 0, 1, 1, 0, 0, 0, 3, 11)});
    vecs.push_back('{dep2,                        mkE(0, 0, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{nop,                         mkE(0, 0, 0, 0, 0, 0, 0, 0, 0)});

    drive(mkI(1, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);

    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].i);
      sbq.push_back(vecs[k].e);
      #3;
      compareOut($sformatf("row%0d", k));
    end

    // Stall saturation: ten load-use stalls against a 3-bit counter.
    step(mkI(1, 0, 0, 0, 0, 0, 0, 0));
    step(mkI(1, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 10; k++) begin
      step(ldr2);
      step(dep2);
    end
    step(nop);
    #3;
    cntq.push_back(16'd10);
    checkCnt("stall_cnt_10", stall_cnt);
    cntq.push_back(16'd7);
    checkCnt("narrow_stall_sat", {13'd0, sStallCnt});
    cntq.push_back(16'd0);
    checkCnt("flush_cnt_zero", flush_cnt);

    // Flush saturation: branch held taken long enough to pin the 16-bit counter.
    step(mkI(0, 0, 0, 0, 0, 0, 0, 1));
    #3;
    sbq.push_back(mkE(0, 0, 1, 1, 0, 0, 0, 10, 0));
    compareOut("branch_only");
    for (int k = 1; k < 65540; k++) begin
      step(mkI(0, 0, 0, 0, 0, 0, 0, 1));
    end
    step(nop);
    #3;
    cntq.push_back(16'hFFFF);
    checkCnt("flush_cnt_sat", flush_cnt);
    cntq.push_back(16'd7);
    checkCnt("narrow_flush_sat", {13'd0, sFlushCnt});
    cntq.push_back(16'd10);
    checkCnt("stall_cnt_hold", stall_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
